// File: rtl/example_pkg.sv
// Shared types and helpers for the serial-datapath round-robin arbiter.
package example_pkg;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  // Index following idx, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/example_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping.
module example_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/example_serial_arb.sv
// Round-robin arbiter that grants one requester per fixed-length frame and
// serialises its bits onto the 1-bit datapath input, with an idle gap between frames.
module example_serial_arb #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 8,
  parameter int GAP_LEN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         bit_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       data_in,
  output logic                       data_valid,
  output logic                       frame_start,
  output logic                       frame_end,
  output logic                       frame_abort
);
  import example_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_LEN);
  localparam state_e AFTER_FRAME = (GAP_LEN == 0) ? IDLE : GAP;

  state_e          state, state_nx;
  logic [CW-1:0]   count;
  logic [3:0]      gap_cnt;
  logic [IW-1:0]   rr_ptr, pick_idx;
  logic            pick_any, own_req, last_bit, gap_done;

  example_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_req  = req[owner];
  assign last_bit = (count == CW'(FRAME_LEN - 1));
  assign gap_done = (gap_cnt == 4'(GAP_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = XFER;
      XFER:    if (!own_req || last_bit) state_nx = AFTER_FRAME;
      GAP:     if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == XFER) gnt[owner] = 1'b1;
  end

  // Counters, pointer and the registered datapath outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= '0;
      rr_ptr      <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      data_in     <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      data_in     <= 1'b0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (pick_any) owner <= pick_idx;
        end
        XFER: begin
          if (own_req) begin
            data_in     <= bit_in[owner];
            data_valid  <= 1'b1;
            frame_start <= (count == '0);
            frame_end   <= last_bit;
          end else begin
            frame_abort <= 1'b1;
          end
          if (!own_req || last_bit) begin
            rr_ptr  <= IW'(rr_next(int'(owner), NUM_REQ));
            count   <= '0;
            gap_cnt <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_example_serial_arb.sv
// Directed bench for example_serial_arb: vector table plus round-robin and zero-gap sequences.
module tb_example_serial_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, bit_in, gnt;
  logic [1:0] owner;
  logic       data_in, data_valid, frame_start, frame_end, frame_abort;

  logic [3:0] req0, bit_in0, gnt0;
  logic [1:0] owner0;
  logic       din0, dv0, fs0, fe0, fa0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  example_serial_arb #(.NUM_REQ(4), .FRAME_LEN(8), .GAP_LEN(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt), .owner(owner),
    .data_in(data_in), .data_valid(data_valid), .frame_start(frame_start),
    .frame_end(frame_end), .frame_abort(frame_abort)
  );

  example_serial_arb #(.NUM_REQ(4), .FRAME_LEN(8), .GAP_LEN(0)) u_dut_gap0 (
    .clk(clk), .rst(rst), .req(req0), .bit_in(bit_in0), .gnt(gnt0), .owner(owner0),
    .data_in(din0), .data_valid(dv0), .frame_start(fs0),
    .frame_end(fe0), .frame_abort(fa0)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       din, dv, fs, fe, fa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] bi,
                     input logic [3:0] g, input logic [1:0] o, input logic d,
                     input logic v, input logic s, input logic e, input logic a);
    vec_t t;
    t.rst = r; t.req = rq; t.bit_in = bi; t.gnt = g; t.owner = o;
    t.din = d; t.dv = v; t.fs = s; t.fe = e; t.fa = a;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int         exp_order[5];
    int         frames, bits, multi, k;

    rst = 1'b1; req = '0; bit_in = '0; req0 = '0; bit_in0 = '0;
    pat = 8'b0100_1101;  // bit i of the frame is pat[i]: 1,0,1,1,0,0,1,0

    // Reset state
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    // Single requester frame on req[2]
    add(0, 4'b0100, 4'b0000, 4'b0100, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'b0100, {1'b0, pat[i], 2'b00}, (i == 7) ? 4'b0000 : 4'b0100, 2,
          pat[i], 1, i == 0, i == 7, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0, 0, 0, 0);
    // Wrap-around: pointer at 3, req 0011 -> 0 then 1
    add(0, 4'b0011, 4'b0000, 4'b0001, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'b0011, (i % 2 == 1) ? 4'b0001 : 4'b1110, (i == 7) ? 4'b0000 : 4'b0001, 0,
          i % 2 == 1, 1, i == 0, i == 7, 0);
    add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0011, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0);
    // Abort: req[1] drops on the 4th grant cycle, req[2] waiting
    for (int i = 0; i < 3; i++)
      add(0, 4'b0110, (i < 2) ? 4'b0010 : 4'b0000, 4'b0010, 1, i < 2, 1, i == 0, 0, 0);
    add(0, 4'b0100, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 1);
    add(0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 4'b0100, 2, 0, 0, 0, 0, 0);
    // Reset at bit 5, then req[3] alone
    for (int i = 0; i < 5; i++)
      add(0, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1, i == 0, 0, 0);
    add(1, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 4'b0000, 4'b1000, 3, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 4'b1000, 4'b1000, 3, 1, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; bit_in = vecs[i].bit_in;
      tick();
      chk($sformatf("vec%0d {gnt,owner,din,dv,fs,fe,fa}", i),
          int'({gnt, owner, data_in, data_valid, frame_start, frame_end, frame_abort}),
          int'({vecs[i].gnt, vecs[i].owner, vecs[i].din, vecs[i].dv,
                vecs[i].fs, vecs[i].fe, vecs[i].fa}));
    end

    // Round-robin with all requests held
    rst = 1'b1; req = '0; tick(); tick();
    rst = 1'b0; req = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
    frames = 0; bits = 0; multi = 0;
    for (int c = 0; c < 200 && frames < 5; c++) begin
      bit_in = 4'($urandom);
      tick();
      if ($countones(gnt) > 1) multi++;
      if (data_valid) bits++;
      if (frame_start) chk($sformatf("rr owner frame%0d", frames), int'(owner), exp_order[frames]);
      if (frame_end) begin
        chk($sformatf("rr bits frame%0d", frames), bits, 8);
        bits = 0;
        frames++;
      end
    end
    chk("rr frames completed", frames, 5);
    chk("rr gnt onehot violations", multi, 0);

    // GAP_LEN=0 instance: 8 valid, 1 idle, repeating
    req = '0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; req0 = 4'b0001;
    k = 0;
    while (!dv0 && k < 20) begin
      bit_in0 = 4'($urandom);
      tick();
      k++;
    end
    chk("gap0 first valid seen", int'(dv0), 1);
    for (int c = 0; c < 27; c++) begin
      chk($sformatf("gap0 dv cycle%0d", c), int'(dv0), int'((c % 9) < 8));
      bit_in0 = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
